usb_gpx_edge_capture: RTL and testbench

- Conditions the asynchronous USB host-controller status pins (GPX, INT) before they reach the CPU.
- Synchronizes the pins, detects edges, and latches them in a sticky edge-capture register.
- Masks the capture register into a registered irq.
- Exposes level, mask and capture registers through a small Avalon-MM slave. This lets software poll or take interrupts instead of sampling a raw level.

---
 rtl/usb_gpx_pkg.sv | 26 ++
 rtl/usb_gpx_sync_filter.sv | 57 +++++
 rtl/usb_gpx_edge_capture.sv | 113 +++++++++++
 tb/tb_usb_gpx_edge_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_gpx_pkg.sv
// usb_gpx_pkg
//   Shared constants and types for the USB GPX/INT edge-capture block.
//   Register map addresses, EDGE_MODE encodings, register width and the
//   internal bus-request struct used by the top level.
//   Optional build macro affecting the block: USB_GPX_DEGLITCH_EN.
package usb_gpx_pkg;

  localparam int REG_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;  // synchronized level (RO)
  localparam logic [1:0] ADDR_RSVD = 2'd1;  // reserved, reads 0
  localparam logic [1:0] ADDR_MASK = 2'd2;  // irq mask (RW)
  localparam logic [1:0] ADDR_EDGE = 2'd3;  // edge capture (W1C)

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // One decoded slave access per cycle.
  typedef struct packed {
    logic             wr;
    logic [1:0]       addr;
    logic [REG_W-1:0] data;
  } bus_req_t;

endpackage

// File: rtl/usb_gpx_sync_filter.sv
// usb_gpx_sync_filter
//   Per-pin conditioning: SYNC_STAGES-deep synchronizer chain, optionally
//   followed by a deglitch filter (build macro USB_GPX_DEGLITCH_EN).
//   With the filter, the output level only follows the synchronized level
//   after it has differed for FILTER_CYCLES consecutive cycles.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   raw asynchronous pin
//   level    out  conditioned level f
module usb_gpx_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= '0;
    else          sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign s = sync[SYNC_STAGES-1];

`ifdef USB_GPX_DEGLITCH_EN
  logic [7:0] cnt;
  logic       f;

  // cnt counts consecutive cycles where s disagrees with f; on the
  // FILTER_CYCLES-th such cycle f takes s, so f lags s by exactly
  // FILTER_CYCLES cycles for a change that holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      f   <= 1'b0;
    end else if (s == f) begin
      cnt <= '0;
    end else if (cnt == 8'(FILTER_CYCLES - 1)) begin
      cnt <= '0;
      f   <= s;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign level = f;
`else
  assign level = s;
`endif

endmodule

// File: rtl/usb_gpx_edge_capture.sv
// usb_gpx_edge_capture
//   Conditions the asynchronous USB host-controller status pins (bit 0 GPX,
//   bit 1 INT), detects edges, latches them in a sticky W1C capture
//   register and raises a registered, masked irq. Registers are exposed on
//   a small Avalon-MM slave with 1-cycle read latency.
//   Build macro USB_GPX_DEGLITCH_EN adds a per-pin stability filter.
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register select (0 level, 1 rsvd, 2 mask, 3 capture)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  registered read data (mux of address every cycle)
//   in_port     in   raw asynchronous pins
//   irq         out  registered |(capture & mask)
module usb_gpx_edge_capture
  import usb_gpx_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int EDGE_MODE     = 0,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // Edges are ignored until the sync chain (and filter) has flushed the
  // reset-time zeros, otherwise pins already high at release would look
  // like rising edges.
`ifdef USB_GPX_DEGLITCH_EN
  localparam int ARM_MAX = SYNC_STAGES + FILTER_CYCLES + 1;
`else
  localparam int ARM_MAX = SYNC_STAGES + 1;
`endif
  localparam int ARM_W = $clog2(ARM_MAX + 1);

  bus_req_t         req;
  logic [WIDTH-1:0] lvl, prev, rise, fall, edge_hit;
  logic [WIDTH-1:0] mask, capture, clr;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed, mask_we;
  logic [31:0]      rdata_nxt;
  logic             unused_wdata;

  assign req = '{wr: chipselect & ~write_n, addr: address, data: writedata};
  assign unused_wdata = &{1'b0, req.data[REG_W-1:WIDTH]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    usb_gpx_sync_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_pin (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .level  (lvl[i])
    );
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;

  always_comb begin
    case (EDGE_MODE)
      EDGE_FALL: edge_hit = fall;
      EDGE_ANY:  edge_hit = rise | fall;
      default:   edge_hit = rise;
    endcase
  end

  assign armed   = (arm_cnt == ARM_W'(ARM_MAX));
  assign mask_we = req.wr && (req.addr == ADDR_MASK);
  assign clr     = (req.wr && (req.addr == ADDR_EDGE)) ? req.data[WIDTH-1:0] : '0;

  always_comb begin
    rdata_nxt = '0;
    case (address)
      ADDR_DATA: rdata_nxt[WIDTH-1:0] = lvl;
      ADDR_MASK: rdata_nxt[WIDTH-1:0] = mask;
      ADDR_EDGE: rdata_nxt[WIDTH-1:0] = capture;
      default:   rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      mask     <= '0;
      capture  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
      arm_cnt  <= '0;
    end else begin
      prev <= lvl;
      if (!armed)  arm_cnt <= arm_cnt + ARM_W'(1);
      if (mask_we) mask    <= req.data[WIDTH-1:0];
      // OR-ing the new edge after the clear lets a same-cycle edge win.
      capture  <= (capture & ~clr) | (edge_hit & {WIDTH{armed}});
      irq      <= |(capture & mask);
      readdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_usb_gpx_edge_capture.sv
module tb_usb_gpx_edge_capture;

  localparam int W  = 2;
  localparam int SS = 2;
  localparam int F  = 4;
`ifdef USB_GPX_DEGLITCH_EN
  localparam int FL = F;
`else
  localparam int FL = 0;
`endif
  localparam int LAT = SS + FL;      // pin sample edge -> capture edge
  localparam int ARM = SS + FL + 1;  // edges before capture is armed

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect, write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd2;
  logic          irq0, irq2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usb_gpx_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(0), .FILTER_CYCLES(F)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));

  usb_gpx_edge_capture #(.WIDTH(W), .SYNC_STAGES(SS), .EDGE_MODE(2), .FILTER_CYCLES(F)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: level is the pin history delayed by the synchronizer
  // depth (then the stability rule if enabled); edges come from comparing
  // successive levels; the register file is tracked per DUT edge mode.
  logic [W-1:0] ph[$];
  int           n = 0;
  logic [W-1:0] fm = '0, prev_m = '0, mask_m = '0;
  int           rc[W];
  logic [W-1:0] cap_m[2];
  logic         irq_m[2];
  logic [31:0]  rd_m[2];
  initial begin
    for (int b = 0; b < W; b++) rc[b] = 0;
    for (int m = 0; m < 2; m++) begin cap_m[m] = '0; irq_m[m] = 1'b0; rd_m[m] = '0; end
  end

  function automatic logic [W-1:0] pin_at(input int k);
    return (k < 1) ? '0 : ph[k-1];
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] s_pre, f_pre, ev, clr;
    logic         wr, armed;
    if (!reset_n) begin
      ph.delete();
      n = 0; fm = '0; prev_m = '0; mask_m = '0;
      for (int b = 0; b < W; b++) rc[b] = 0;
      for (int m = 0; m < 2; m++) begin cap_m[m] = '0; irq_m[m] = 1'b0; rd_m[m] = '0; end
    end else begin
      n++;
      s_pre = pin_at(n - SS);
      f_pre = (FL == 0) ? s_pre : fm;
      if (FL != 0) begin
        for (int b = 0; b < W; b++) begin
          if (s_pre[b] != fm[b]) begin
            rc[b]++;
            if (rc[b] == FL) begin fm[b] = s_pre[b]; rc[b] = 0; end
          end else rc[b] = 0;
        end
      end
      armed = (n > ARM);
      wr    = chipselect && !write_n;
      clr   = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int m = 0; m < 2; m++) begin
        ev = (m == 0) ? (f_pre & ~prev_m) : (f_pre ^ prev_m);
        case (address)
          2'd0:    rd_m[m] = 32'(f_pre);
          2'd2:    rd_m[m] = 32'(mask_m);
          2'd3:    rd_m[m] = 32'(cap_m[m]);
          default: rd_m[m] = 32'd0;
        endcase
        irq_m[m] = |(cap_m[m] & mask_m);
        cap_m[m] = (cap_m[m] & ~clr) | (armed ? ev : '0);
      end
      if (wr && address == 2'd2) mask_m = writedata[W-1:0];
      prev_m = f_pre;
      ph.push_back(in_port);
    end
  end

  always @(negedge clk) begin
    chk("rd_rise",  rd0,  rd_m[0]);
    chk("irq_rise", 32'(irq0), 32'(irq_m[0]));
    chk("rd_any",   rd2,  rd_m[1]);
    chk("irq_any",  32'(irq2), 32'(irq_m[1]));
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_port = '1; address = 2'd3;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cyc(3);
    chk("reset_rd",  rd0, 32'd0);
    chk("reset_irq", 32'(irq0), 32'd0);
    reset_n = 1'b1;

    // pins high at release: no spurious capture, level eventually 2'b11
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("arm_cap_rise", rd0, 32'd0);
      chk("arm_cap_any",  rd2, 32'd0);
      chk("arm_irq",      32'(irq0 | irq2), 32'd0);
    end
    address = 2'd0;
    cyc(1);
    chk("level_11", rd0, 32'd3);

    // GPX rise with mask=01 -> irq 3 edges later, W1C drops it next cycle
    in_port = '0;
    cyc(LAT + 4);
    wr_reg(2'd3, 32'hFF);
    wr_reg(2'd2, 32'h1);
    address = 2'd3;
    in_port = 2'b01;
    cyc(LAT + 1);
    chk("gpx_irq_early", 32'(irq0), 32'd0);
    cyc(1);
    chk("gpx_irq",     32'(irq0), 32'd1);
    chk("gpx_irq_any", 32'(irq2), 32'd1);
    chk("gpx_cap",     rd0, 32'd1);
    wr_reg(2'd3, 32'h1);
    chk("w1c_irq_hold", 32'(irq0), 32'd1);
    cyc(1);
    chk("w1c_irq_drop", 32'(irq0), 32'd0);

    // INT rise with mask=0, then unmask
    wr_reg(2'd2, 32'h0);
    address = 2'd3;
    in_port = 2'b11;
    cyc(LAT + 3);
    chk("int_cap", rd0, 32'd2);
    chk("int_irq_masked", 32'(irq0), 32'd0);
    wr_reg(2'd2, 32'h2);
    chk("unmask_irq_early", 32'(irq0), 32'd0);
    cyc(1);
    chk("unmask_irq", 32'(irq0), 32'd1);

    // edge and W1C of the same bit on the same edge: set wins
    wr_reg(2'd2, 32'h0);
    wr_reg(2'd3, 32'h3);
    in_port = 2'b10;
    cyc(LAT + 3);
    wr_reg(2'd3, 32'h3);
    in_port = 2'b11;
    cyc(LAT);
    wr_reg(2'd3, 32'h1);
    address = 2'd3;
    cyc(1);
    chk("set_wins_rise", rd0, 32'd1);
    chk("set_wins_any",  rd2, 32'd1);

    // any-edge mode catches both transitions; reserved reads 0
    wr_reg(2'd3, 32'h3);
    address = 2'd3;
    in_port = 2'b10;
    cyc(LAT + 3);
    chk("fall_any",  rd2, 32'd1);
    chk("fall_rise", rd0, 32'd0);
    wr_reg(2'd3, 32'h1);
    address = 2'd1;
    cyc(1);
    chk("rsvd_rd", rd0, 32'd0);
    wr_reg(2'd1, 32'hFFFF_FFFF);
    cyc(1);
    chk("rsvd_wr", rd2, 32'd0);
    address = 2'd3;
    in_port = 2'b11;
    cyc(LAT + 3);
    chk("rise_any",  rd2, 32'd1);
    chk("rise_rise", rd0, 32'd1);

`ifdef USB_GPX_DEGLITCH_EN
    // 3-cycle glitch rejected, 5-cycle pulse captured FILTER_CYCLES later
    wr_reg(2'd3, 32'h3);
    in_port = 2'b10;
    cyc(LAT + 4);
    wr_reg(2'd3, 32'h3);
    address = 2'd3;
    in_port = 2'b11;
    cyc(3);
    in_port = 2'b10;
    cyc(LAT + 6);
    chk("glitch_cap_rise", rd0, 32'd0);
    chk("glitch_cap_any",  rd2, 32'd0);
    address = 2'd0;
    cyc(1);
    chk("glitch_level", rd0, 32'd2);
    address = 2'd3;
    in_port = 2'b11;
    cyc(5);
    in_port = 2'b10;
    cyc(LAT - 4);
    chk("pulse_cap_early", rd0, 32'd0);
    cyc(1);
    chk("pulse_cap", rd0, 32'd1);
`endif

    // randomized traffic against the model, with one mid-run reset
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
      address    = 2'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = 1'($urandom);
      writedata  = $urandom;
      if (i == 1200) begin
        #1 reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
